// File: rtl/part2_mac.sv
// Signed 10x10 multiply-accumulate into a 20-bit wrapping accumulator.
// Latency: 2 edges from a valid (a, b) pair to f/valid_out; one pair per cycle.
// No backpressure: every valid_in pair is accepted and accumulated exactly once.
module part2_mac #(
  parameter int IN_WIDTH  = 10,
  parameter int OUT_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  a,
  input  logic [IN_WIDTH-1:0]  b,
  input  logic                 valid_in,
  output logic [OUT_WIDTH-1:0] f,
  output logic                 valid_out
);

  // Stage 1: captured operands and their valid flag
  logic [IN_WIDTH-1:0]  a_q, a_d;
  logic [IN_WIDTH-1:0]  b_q, b_d;
  logic                 en_q, en_d;

  // Stage 2: accumulator and its update flag
  logic [OUT_WIDTH-1:0] f_q, f_d;
  logic                 vout_q, vout_d;

  // Operands sign-extended to the accumulator width so the product is a
  // full signed product, and the sum wraps naturally modulo 2^OUT_WIDTH.
  logic signed [OUT_WIDTH-1:0] a_ext;
  logic signed [OUT_WIDTH-1:0] b_ext;
  logic signed [OUT_WIDTH-1:0] prod;

  // Sign extension and multiply of the registered operands
  always_comb begin
    a_ext = $signed({{(OUT_WIDTH-IN_WIDTH){a_q[IN_WIDTH-1]}}, a_q});
    b_ext = $signed({{(OUT_WIDTH-IN_WIDTH){b_q[IN_WIDTH-1]}}, b_q});
    prod  = a_ext * b_ext;
  end

  // Next-state for both pipeline stages; operands and f hold when idle
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    en_d   = valid_in;
    f_d    = f_q;
    vout_d = en_q;
    if (valid_in) begin
      a_d = a;
      b_d = b;
    end
    if (en_q) begin
      f_d = f_q + prod;
    end
  end

  // Pipeline registers; reset discards any pair still in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      en_q   <= 1'b0;
      f_q    <= '0;
      vout_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      en_q   <= en_d;
      f_q    <= f_d;
      vout_q <= vout_d;
    end
  end

  assign f         = f_q;
  assign valid_out = vout_q;

endmodule

// File: tb/tb_part2_mac.sv
// Directed and randomized checks of the part2_mac multiply-accumulate unit.
// Inputs change 1ns after each rising edge; outputs are sampled there too.
// The DUT has no backpressure, so every step is a fixed number of edges.
module tb_part2_mac;

  logic        clk;
  logic        reset;
  logic [9:0]  a;
  logic [9:0]  b;
  logic        valid_in;
  logic [19:0] f;
  logic        valid_out;

  int vectors;
  int miscompares;

  part2_mac #(.IN_WIDTH(10), .OUT_WIDTH(20)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .valid_in  (valid_in),
    .f         (f),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [9:0] av, input logic [9:0] bv, input logic v);
    a        = av;
    b        = bv;
    valid_in = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(10'd0, 10'd0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(10'd7, 10'd9, 1'b1);
    tick();
    tick();
    vectors++;
    if (valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_vout: got %b want 0", valid_out);
    end
    vectors++;
    if (f !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_f: got %0d want 0", $signed(f));
    end
    reset = 1'b0;
    drive(10'd0, 10'd0, 1'b0);
  endtask

  task automatic test_single();
    do_reset();
    drive(10'd2, 10'd3, 1'b1);
    tick();
    vectors++;
    if (valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL single_lat1_vout: got %b want 0", valid_out);
    end
    drive(10'd0, 10'd0, 1'b0);
    tick();
    vectors++;
    if (valid_out !== 1'b1 || f !== 20'd6) begin
      miscompares++;
      $display("FAIL single_acc: got vout=%b f=%0d want vout=1 f=6", valid_out, $signed(f));
    end
    tick();
    vectors++;
    if (valid_out !== 1'b0 || f !== 20'd6) begin
      miscompares++;
      $display("FAIL single_hold: got vout=%b f=%0d want vout=0 f=6", valid_out, $signed(f));
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(10'd2, 10'd3, 1'b1);
    tick();
    drive(-10'sd4, 10'd5, 1'b1);
    tick();
    vectors++;
    if (valid_out !== 1'b1 || f !== 20'd6) begin
      miscompares++;
      $display("FAIL b2b_1: got vout=%b f=%0d want vout=1 f=6", valid_out, $signed(f));
    end
    drive(10'd7, -10'sd1, 1'b1);
    tick();
    vectors++;
    if (valid_out !== 1'b1 || f !== -20'sd14) begin
      miscompares++;
      $display("FAIL b2b_2: got vout=%b f=%0d want vout=1 f=-14", valid_out, $signed(f));
    end
    drive(10'd0, 10'd0, 1'b0);
    tick();
    vectors++;
    if (valid_out !== 1'b1 || f !== -20'sd21) begin
      miscompares++;
      $display("FAIL b2b_3: got vout=%b f=%0d want vout=1 f=-21", valid_out, $signed(f));
    end
    tick();
    vectors++;
    if (valid_out !== 1'b0 || f !== -20'sd21) begin
      miscompares++;
      $display("FAIL b2b_idle: got vout=%b f=%0d want vout=0 f=-21", valid_out, $signed(f));
    end
  endtask

  task automatic test_bubble();
    do_reset();
    drive(10'd10, 10'd10, 1'b1);
    tick();
    drive(10'd99, 10'd77, 1'b0);
    tick();
    vectors++;
    if (valid_out !== 1'b1 || f !== 20'd100) begin
      miscompares++;
      $display("FAIL bubble_1: got vout=%b f=%0d want vout=1 f=100", valid_out, $signed(f));
    end
    drive(-10'sd3, -10'sd3, 1'b1);
    tick();
    vectors++;
    if (valid_out !== 1'b0 || f !== 20'd100) begin
      miscompares++;
      $display("FAIL bubble_gap: got vout=%b f=%0d want vout=0 f=100", valid_out, $signed(f));
    end
    drive(10'd0, 10'd0, 1'b0);
    tick();
    vectors++;
    if (valid_out !== 1'b1 || f !== 20'd109) begin
      miscompares++;
      $display("FAIL bubble_2: got vout=%b f=%0d want vout=1 f=109", valid_out, $signed(f));
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(-10'sd512, -10'sd512, 1'b1);
    tick();
    tick();
    vectors++;
    if (valid_out !== 1'b1 || f !== 20'd262144) begin
      miscompares++;
      $display("FAIL wrap_1: got vout=%b f=%0d want vout=1 f=262144", valid_out, $signed(f));
    end
    drive(10'd0, 10'd0, 1'b0);
    tick();
    vectors++;
    if (valid_out !== 1'b1 || f !== 20'h80000) begin
      miscompares++;
      $display("FAIL wrap_2: got vout=%b f=%h want vout=1 f=80000", valid_out, f);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    drive(10'd5, 10'd5, 1'b1);
    tick();
    reset = 1'b1;
    drive(10'd0, 10'd0, 1'b0);
    tick();
    vectors++;
    if (valid_out !== 1'b0 || f !== 20'd0) begin
      miscompares++;
      $display("FAIL midrst_during: got vout=%b f=%0d want vout=0 f=0", valid_out, $signed(f));
    end
    reset = 1'b0;
    drive(10'd1, 10'd1, 1'b1);
    tick();
    vectors++;
    if (valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_flush: got vout=%b want 0", valid_out);
    end
    drive(10'd0, 10'd0, 1'b0);
    tick();
    vectors++;
    if (valid_out !== 1'b1 || f !== 20'd1) begin
      miscompares++;
      $display("FAIL midrst_first: got vout=%b f=%0d want vout=1 f=1", valid_out, $signed(f));
    end
  endtask

  // Golden model state: behavioural two-stage MAC
  logic signed [9:0]  m_a, m_b;
  logic               m_en, m_v;
  logic signed [19:0] m_f;

  task automatic test_random();
    logic signed [19:0] m_prod;
    do_reset();
    m_a = '0; m_b = '0; m_en = 1'b0; m_v = 1'b0; m_f = '0;
    for (int i = 0; i < 1000; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      drive(10'($urandom), 10'($urandom), 1'($urandom_range(0, 3) != 0));
      if (reset) begin
        m_a = '0; m_b = '0; m_en = 1'b0; m_v = 1'b0; m_f = '0;
      end else begin
        m_prod = 20'(m_a) * 20'(m_b);
        m_v = m_en;
        if (m_en) m_f = m_f + m_prod;
        m_en = valid_in;
        if (valid_in) begin
          m_a = a;
          m_b = b;
        end
      end
      tick();
      vectors++;
      if (valid_out !== m_v) begin
        miscompares++;
        $display("FAIL rand_vout cycle %0d: got %b want %b", i, valid_out, m_v);
      end
      if (m_v) begin
        vectors++;
        if (f !== m_f) begin
          miscompares++;
          $display("FAIL rand_f cycle %0d: got %0d want %0d", i, $signed(f), m_f);
        end
      end
    end
    reset = 1'b0;
    drive(10'd0, 10'd0, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    a           = '0;
    b           = '0;
    valid_in    = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_bubble();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
